// File: rtl/down_counter_timer.sv
// Programmable synchronous down-counter/timer with one-shot and auto-reload modes.
// Flags terminal count with a registered one-cycle pulse on the 1->0 edge.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (count_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (!pause) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              count_d = '0;
              tc_d    = 1'b1;
              state_d = auto_reload ? RUN : DONE;
            end else if (reload_q != '0) begin
              // Zero-count cycle in periodic mode: reload and keep running.
              count_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus random
// stimulus, all compared against a behavioural timer model.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] count_out;
  logic       tc, busy, done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
  int m_cnt = 0, m_rel = 0, m_mode = 0, m_tc = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .count_out(count_out), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (reset) begin
      m_cnt = 0; m_rel = 0; m_mode = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_rel = int'(load_val); m_cnt = int'(load_val); m_mode = 0;
      end else if (m_mode == 0) begin
        if (start && m_cnt > 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!pause) begin
          if (m_cnt > 1) m_cnt = m_cnt - 1;
          else if (m_cnt == 1) begin
            m_cnt = 0; m_tc = 1; m_mode = auto_reload ? 1 : 2;
          end else if (m_rel > 0) m_cnt = m_rel;
          else m_mode = 2;
        end
      end else if (start) begin
        if (m_rel > 0) begin m_cnt = m_rel; m_mode = 1; end
        else m_mode = 0;
      end
    end
  endtask

  // Advance one clock: model consumes the same inputs the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs();
    return {count_out, tc, busy, done};
  endfunction

  function automatic logic [6:0] expv();
    return {4'(m_cnt), m_tc[0], (m_mode == 1), (m_mode == 2)};
  endfunction

  task automatic set_in(input logic l, input logic [3:0] v, input logic s,
                        input logic p, input logic a);
    load = l; load_val = v; start = s; pause = p; auto_reload = a;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b1, 4'd7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs() !== 7'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b want 0000000", i, obs());
      end
    end
    reset = 1'b0;
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_one_shot();
    int busy_n = 0, tc_n = 0, guard = 0;
    set_in(1'b1, 4'd5, 1'b0, 1'b0, 1'b0); tick();
    checks++;
    if (count_out !== 4'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL load_latency: got cnt=%0d busy=%b want 5/0", count_out, busy);
    end
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    start = 1'b0;
    checks++;
    if (count_out !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL first_run_cycle: got cnt=%0d busy=%b want 5/1", count_out, busy);
    end
    while (!done && guard < 20) begin
      busy_n += int'(busy);
      tick(); guard++;
      tc_n += int'(tc);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL one_shot: got %b want %b", obs(), expv());
      end
    end
    checks++;
    if (busy_n != 5 || tc_n != 1 || count_out !== 4'd0 || guard >= 20) begin
      errors++;
      $display("FAIL one_shot_totals: got busy=%0d tc=%0d cnt=%0d want 5/1/0", busy_n, tc_n, count_out);
    end
    tick();
    checks++;
    if (tc !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL tc_pulse_width: got tc=%b done=%b want 0/1", tc, done);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (count_out !== 4'd5 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL restart: got cnt=%0d busy=%b done=%b want 5/1/0", count_out, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL restart_run: got %b want %b", obs(), expv());
      end
    end
  endtask

  task automatic test_pause();
    set_in(1'b1, 4'd4, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    start = 1'b0;
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count_out !== 4'd2 || tc !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL pause_hold: got cnt=%0d tc=%b busy=%b want 2/0/1", count_out, tc, busy);
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs() !== expv() || count_out !== 4'(1 - i)) begin
        errors++; $display("FAIL pause_resume: got %b want %b", obs(), expv());
      end
    end
  endtask

  task automatic test_auto_reload();
    int tc_n = 0, done_n = 0, guard = 0;
    set_in(1'b1, 4'd3, 1'b0, 1'b0, 1'b1); tick();
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b1); tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tc_n += int'(tc); done_n += int'(done);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL auto_reload: got %b want %b", obs(), expv());
      end
    end
    checks++;
    if (tc_n != 3 || done_n != 0 || count_out !== 4'd3) begin
      errors++; $display("FAIL auto_totals: got tc=%0d done=%0d cnt=%0d want 3/0/3", tc_n, done_n, count_out);
    end
    auto_reload = 1'b0;
    while (!done && guard < 10) begin tick(); guard++; end
    checks++;
    if (guard != 3 || count_out !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL auto_drop: got cycles=%0d cnt=%0d busy=%b want 3/0/0", guard, count_out, busy);
    end
  endtask

  task automatic test_load_abort();
    set_in(1'b1, 4'd10, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    set_in(1'b1, 4'd9, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (count_out !== 4'd9 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL load_abort: got cnt=%0d busy=%b tc=%b want 9/0/0", count_out, busy, tc);
    end
    set_in(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick(); tick();
    start = 1'b0;
    checks++;
    if (obs() !== 7'b0) begin
      errors++; $display("FAIL zero_start: got %b want 0000000", obs());
    end
  endtask

  task automatic test_reset_midrun();
    set_in(1'b1, 4'd15, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (count_out !== 4'd8) begin
      errors++; $display("FAIL midrun_pre: got cnt=%0d want 8", count_out);
    end
    reset = 1'b1; set_in(1'b1, 4'd6, 1'b1, 1'b0, 1'b0); tick();
    reset = 1'b0; set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== 7'b0) begin
      errors++; $display("FAIL midrun_reset: got %b want 0000000", obs());
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (obs() !== 7'b0) begin
      errors++; $display("FAIL start_after_reset: got %b want 0000000", obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      load = ($urandom_range(0, 99) < 8);
      load_val = 4'($urandom);
      start = ($urandom_range(0, 99) < 25);
      pause = ($urandom_range(0, 99) < 20);
      auto_reload = ($urandom_range(0, 99) < 50);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
      end
    end
    reset = 1'b0; set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    test_reset();
    test_one_shot();
    test_pause();
    test_auto_reload();
    test_load_abort();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
